// File: rtl/graph_renderer_pkg.sv
// rtl/graph_renderer_pkg.sv - shared constants and helpers for the strip-chart renderer
package graph_renderer_pkg;

  localparam int SCREEN_COLUMNS = 128;
  localparam int SCREEN_PAGES   = 8;
  localparam int HEIGHT_BITS    = 6;
  localparam int COL_W          = $clog2(SCREEN_COLUMNS);
  localparam int PAGE_W         = $clog2(SCREEN_PAGES);

  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_POINT = 2'd1,
    MODE_LINE  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // (7 - page) * 8 + (7 - bit) reduces to inverting both fields.
  function automatic logic [HEIGHT_BITS-1:0] row_height(input logic [PAGE_W-1:0] page,
                                                        input logic [2:0] bit_idx);
    return {~page, ~bit_idx};
  endfunction

endpackage

// File: rtl/graph_renderer_column_rasterizer.sv
// rtl/graph_renderer_column_rasterizer.sv - turns column heights into one page byte
module column_rasterizer
  import graph_renderer_pkg::*;
(
  input  logic [HEIGHT_BITS-1:0] h_i,
  input  logic [HEIGHT_BITS-1:0] hp_i,
  input  logic [PAGE_W-1:0]      page_i,
  input  logic [1:0]             mode_i,
  output logic [7:0]             page_byte_o
);

  logic [HEIGHT_BITS-1:0] lo;
  logic [HEIGHT_BITS-1:0] hi;
  logic [HEIGHT_BITS-1:0] r;
  logic                   lit;

  always_comb begin
    lo          = (h_i < hp_i) ? h_i : hp_i;
    hi          = (h_i < hp_i) ? hp_i : h_i;
    r           = '0;
    lit         = 1'b0;
    page_byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      r = row_height(page_i, 3'(i));
      case (mode_i)
        MODE_POINT: lit = (r == h_i);
        MODE_LINE:  lit = (r >= lo) && (r <= hi);
        default:    lit = (r <= h_i);
      endcase
      page_byte_o[i] = lit;
    end
  end

endmodule

// File: rtl/graph_renderer.sv
// rtl/graph_renderer.sv - scrolling strip-chart renderer for a 128x64 page-addressed display
module graph_renderer
  import graph_renderer_pkg::*;
#(
  parameter int SAMPLE_BITS = 8,
  parameter int AVG_LOG2    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sampleValid,
  output logic                   sampleReady,
  input  logic [SAMPLE_BITS-1:0] sampleData,
  input  logic [1:0]             mode,
  input  logic                   freeze,
  input  logic [9:0]             pixelAddress,
  output logic [7:0]             pixelData,
  output logic [6:0]             columnCount
);

  localparam int ACC_W = SAMPLE_BITS + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic                   sample_ready_q;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COL_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [SAMPLE_BITS-1:0] col_buf_q [SCREEN_COLUMNS];
  logic [7:0]             pixel_data_q;

  logic                   take;
  logic                   col_we;
  logic [ACC_W-1:0]       acc_sum;
  logic [ACC_W-1:0]       acc_shift;
  logic [SAMPLE_BITS-1:0] col_value;

  always_comb begin
    take      = sampleValid & sample_ready_q & ~freeze;
    acc_sum   = acc_q + ACC_W'(sampleData);
    acc_shift = acc_sum >> AVG_LOG2;
    col_value = acc_shift[SAMPLE_BITS-1:0];
    col_we    = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    if (take) begin
      if (cnt_q == CNT_LAST) begin
        col_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_ready_q <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      for (int i = 0; i < SCREEN_COLUMNS; i++) begin
        col_buf_q[i] <= '0;
      end
    end else begin
      sample_ready_q <= 1'b1;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      if (col_we) begin
        col_buf_q[wr_ptr_q] <= col_value;
      end
    end
  end

  // Display column 0 is the oldest slot, i.e. the one about to be overwritten.
  logic [COL_W-1:0]       rd_col;
  logic [PAGE_W-1:0]      rd_page;
  logic [COL_W-1:0]       rd_slot;
  logic [COL_W-1:0]       rd_prev;
  logic [SAMPLE_BITS-1:0] cur_val;
  logic [SAMPLE_BITS-1:0] prev_val;
  logic [HEIGHT_BITS-1:0] h;
  logic [HEIGHT_BITS-1:0] hp;
  logic [7:0]             page_byte;

  always_comb begin
    rd_col   = pixelAddress[6:0];
    rd_page  = pixelAddress[9:7];
    rd_slot  = wr_ptr_q + rd_col;
    rd_prev  = rd_slot - 1'b1;
    cur_val  = col_buf_q[rd_slot];
    prev_val = col_buf_q[rd_prev];
    h        = cur_val[SAMPLE_BITS-1 -: HEIGHT_BITS];
    hp       = (rd_col == '0) ? h : prev_val[SAMPLE_BITS-1 -: HEIGHT_BITS];
  end

  column_rasterizer u_rasterizer (
    .h_i         (h),
    .hp_i        (hp),
    .page_i      (rd_page),
    .mode_i      (mode),
    .page_byte_o (page_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_data_q <= '0;
    end else begin
      pixel_data_q <= page_byte;
    end
  end

  assign sampleReady = sample_ready_q;
  assign pixelData   = pixel_data_q;
  assign columnCount = wr_ptr_q;

endmodule
